// File: rtl/jzjpcc_pkg.sv
// jzjpcc_pkg
//   Definitions shared by the jzjpcc pipeline stages (fetch, decode, control).
//   - NOP_INSTR / NOP_WORD : canonical RV32I NOP (addi x0,x0,0); the stages carry
//     instructions as bits [31:2] only, because RV32I encodings always end in 2'b11.
//   - instr_word_t         : an instruction with its constant low bits dropped.
//   - pc_width()           : width of a word PC whose MSB index is pc_max_b (PC is [pc_max_b:2]).
package jzjpcc_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam logic [29:0] NOP_WORD  = NOP_INSTR[31:2];

  typedef logic [29:0] instr_word_t;

  function automatic int pc_width(input int pc_max_b);
    return pc_max_b - 1;
  endfunction

endpackage

// File: rtl/jzjpcc_fetch_holdbuf.sv
// jzjpcc_fetch_holdbuf
//   Keeps the instruction shown to decode stable while fetch is stalled. The
//   memory read data moves on to the word at the held PC during a stall, so the
//   word on display is captured on the first stalled edge and replayed until
//   the stall is released.
// Ports
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-low reset
//   hold         in   fetch is stalled this cycle (a redirect already removed)
//   bubble       in   decode must see a NOP
//   mem_word     in   instruction memory read data, bits [31:2]
//   instruction  out  instruction presented to decode, bits [31:2]
module jzjpcc_fetch_holdbuf
  import jzjpcc_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        hold,
  input  logic        bubble,
  input  instr_word_t mem_word,
  output instr_word_t instruction
);

  instr_word_t hold_q;
  logic        hold_v;

  always_ff @(posedge clock) begin
    if (!reset) begin
      hold_q <= '0;
      hold_v <= 1'b0;
    end else if (hold) begin
      // Capture only once; later stalled cycles would grab the next word.
      if (!hold_v) begin
        hold_q <= mem_word;
        hold_v <= 1'b1;
      end
    end else begin
      hold_v <= 1'b0;
    end
  end

  assign instruction = bubble ? NOP_WORD : (hold_v ? hold_q : mem_word);

endmodule

// File: rtl/jzjpcc_fetch.sv
// jzjpcc_fetch
//   Fetch stage of the jzjpcc pipeline, directly upstream of decode. Owns the
//   PC, addresses a synchronous (1-cycle latency) instruction memory and
//   presents {instruction_decode, currentPC_decode} to decode. Handles
//   redirects, stalls and bubble insertion.
// Parameters
//   PC_MAX_B  MSB index of the word PC; PCs are [PC_MAX_B:2]
//   RESET_PC  byte address fetched first after reset (bits [1:0] ignored)
// Ports
//   clock                 in   rising-edge clock
//   reset                 in   synchronous, active-low reset
//   instAddr              out  word address to instruction memory (= pc)
//   instMemData           in   memory read data, valid one cycle after instAddr
//   instruction_decode    out  instruction [31:2] to decode
//   currentPC_decode      out  PC of instruction_decode
//   pcCTWriteEnable       in   redirect: next fetch PC is controlTransferNewPC
//   controlTransferNewPC  in   redirect target
//   stall_fetch           in   hold PC and decode outputs this cycle
//   flush_decode          in   show a NOP to decode after the next edge
//   perfFetched           out  (JZJPCC_FETCH_PERF_COUNTERS_EN) real instructions loaded
//   perfBubbles           out  (JZJPCC_FETCH_PERF_COUNTERS_EN) bubbles loaded
// Configuration
//   JZJPCC_FETCH_PERF_COUNTERS_EN : adds the two free-running 32-bit counters.
module jzjpcc_fetch
  import jzjpcc_pkg::*;
#(
  parameter int          PC_MAX_B = 15,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [PC_MAX_B-2:0]  instAddr,
  input  logic [31:0]          instMemData,
  output logic [29:0]          instruction_decode,
  output logic [PC_MAX_B-2:0]  currentPC_decode,
  input  logic                 pcCTWriteEnable,
  input  logic [PC_MAX_B-2:0]  controlTransferNewPC,
  input  logic                 stall_fetch,
  input  logic                 flush_decode
`ifdef JZJPCC_FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]          perfFetched,
  output logic [31:0]          perfBubbles
`endif
);

  localparam int PCW = pc_width(PC_MAX_B);
  localparam logic [PCW-1:0] RESET_WORD = RESET_PC[PC_MAX_B:2];

  logic [PCW-1:0] pc;
  logic [PCW-1:0] pc_next;
  logic           bubble;
  logic           bubble_next;
  logic           stalled;
  logic           mem_low_unused;

  // A redirect overrides a stall: the wrong-path word is dropped via the bubble.
  assign stalled = stall_fetch & ~pcCTWriteEnable;

  // Low two bits of an RV32I encoding are always 2'b11 and carry no information.
  assign mem_low_unused = ^instMemData[1:0];

  always_comb begin
    pc_next     = pc + PCW'(1);
    bubble_next = pcCTWriteEnable | flush_decode | (stalled & bubble);
    if (pcCTWriteEnable) begin
      pc_next = controlTransferNewPC;
    end else if (stalled) begin
      pc_next = pc;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc               <= RESET_WORD;
      currentPC_decode <= RESET_WORD;
      bubble           <= 1'b1;
    end else begin
      pc     <= pc_next;
      bubble <= bubble_next;
      if (!stalled) begin
        currentPC_decode <= pc;
      end
    end
  end

  assign instAddr = pc;

  jzjpcc_fetch_holdbuf u_holdbuf (
    .clock       (clock),
    .reset       (reset),
    .hold        (stalled),
    .bubble      (bubble),
    .mem_word    (instMemData[31:2]),
    .instruction (instruction_decode)
  );

`ifdef JZJPCC_FETCH_PERF_COUNTERS_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      perfFetched <= '0;
      perfBubbles <= '0;
    end else begin
      if (!stalled && !bubble_next) begin
        perfFetched <= perfFetched + 32'd1;
      end
      if (bubble_next) begin
        perfBubbles <= perfBubbles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_jzjpcc_fetch.sv
// tb_jzjpcc_fetch
//   Scoreboard bench for jzjpcc_fetch. A stimulus process drives one input set
//   per cycle on the falling edge, advances an instruction-level model of what
//   decode should see, and queues the expectation. A monitor pops one entry
//   after every rising edge and compares. Memory word at address a is
//   {2'b10, a^14'h1555, a, 2'b11} with random bits [1:0] on every read.
module tb_jzjpcc_fetch;

  localparam int          PC_MAX_B = 15;
  localparam int          PCW      = PC_MAX_B - 1;
  localparam logic [31:0] RST_BYTE = 32'h100;
  localparam logic [29:0] NOP      = 30'h4;

  logic            clock;
  logic            reset;
  logic [PCW-1:0]  instAddr;
  logic [31:0]     instMemData;
  logic [29:0]     instruction_decode;
  logic [PCW-1:0]  currentPC_decode;
  logic            pcCTWriteEnable;
  logic [PCW-1:0]  controlTransferNewPC;
  logic            stall_fetch;
  logic            flush_decode;
`ifdef JZJPCC_FETCH_PERF_COUNTERS_EN
  logic [31:0]     perfFetched;
  logic [31:0]     perfBubbles;
`endif

  jzjpcc_fetch #(.PC_MAX_B(PC_MAX_B), .RESET_PC(RST_BYTE)) dut (
    .clock                (clock),
    .reset                (reset),
    .instAddr             (instAddr),
    .instMemData          (instMemData),
    .instruction_decode   (instruction_decode),
    .currentPC_decode     (currentPC_decode),
    .pcCTWriteEnable      (pcCTWriteEnable),
    .controlTransferNewPC (controlTransferNewPC),
    .stall_fetch          (stall_fetch),
    .flush_decode         (flush_decode)
`ifdef JZJPCC_FETCH_PERF_COUNTERS_EN
    ,
    .perfFetched          (perfFetched),
    .perfBubbles          (perfBubbles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [PCW-1:0] a);
    return {2'b10, a ^ 14'h1555, a, 2'b11};
  endfunction

  logic [1:0] low_noise;
  always @(posedge clock) begin
    low_noise = 2'($urandom_range(0, 3));
    instMemData <= mem_word(instAddr) ^ {30'b0, low_noise};
  end

  typedef struct {
    logic [PCW-1:0] addr;
    logic [PCW-1:0] cpc;
    logic [29:0]    instr;
    logic [31:0]    pf;
    logic [31:0]    pb;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Model: the PC to fetch next, and what decode currently shows.
  logic [PCW-1:0] m_pc;
  logic [PCW-1:0] m_cpc;
  logic [29:0]    m_instr;
  logic           m_is_bubble;
  logic [31:0]    m_pf;
  logic [31:0]    m_pb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clock) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("instAddr", 32'(instAddr), 32'(e.addr));
      chk("currentPC_decode", 32'(currentPC_decode), 32'(e.cpc));
      chk("instruction_decode", 32'(instruction_decode), 32'(e.instr));
`ifdef JZJPCC_FETCH_PERF_COUNTERS_EN
      chk("perfFetched", perfFetched, e.pf);
      chk("perfBubbles", perfBubbles, e.pb);
`endif
    end
  end

  task automatic step(input bit rst_b, input bit redir, input logic [PCW-1:0] tgt,
                      input bit st, input bit fl);
    exp_t e;
    @(negedge clock);
    reset                = rst_b;
    pcCTWriteEnable      = redir;
    controlTransferNewPC = tgt;
    stall_fetch          = st;
    flush_decode         = fl;
    if (!rst_b) begin
      m_pc        = RST_BYTE[PC_MAX_B:2];
      m_cpc       = RST_BYTE[PC_MAX_B:2];
      m_instr     = NOP;
      m_is_bubble = 1'b1;
      m_pf        = 0;
      m_pb        = 0;
    end else if (redir) begin
      // Decode sees the slot of the wrong-path fetch as a NOP.
      m_cpc       = m_pc;
      m_instr     = NOP;
      m_is_bubble = 1'b1;
      m_pc        = tgt;
      m_pb++;
    end else if (st) begin
      // Decode output frozen; a flush still turns it into a NOP.
      if (fl) begin
        m_instr     = NOP;
        m_is_bubble = 1'b1;
      end
      if (m_is_bubble) m_pb++;
    end else begin
      m_cpc = m_pc;
      if (fl) begin
        m_instr     = NOP;
        m_is_bubble = 1'b1;
        m_pb++;
      end else begin
        m_instr     = mem_word(m_pc) >> 2;
        m_is_bubble = 1'b0;
        m_pf++;
      end
      m_pc = m_pc + 14'd1;
    end
    e.addr  = m_pc;
    e.cpc   = m_cpc;
    e.instr = m_instr;
    e.pf    = m_pf;
    e.pb    = m_pb;
    exp_q.push_back(e);
  endtask

  initial begin
    reset                = 1'b0;
    pcCTWriteEnable      = 1'b0;
    controlTransferNewPC = '0;
    stall_fetch          = 1'b0;
    flush_decode         = 1'b0;
    m_pc = '0; m_cpc = '0; m_instr = NOP; m_is_bubble = 1'b1; m_pf = 0; m_pb = 0;

    // Reset, then straight-line fetch from 0x40.
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, '0, 0, 0);
    // Stall three cycles with 0x42 on display, then release.
    for (int i = 0; i < 3; i++) step(1, 0, '0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, '0, 0, 0);
    // Redirect to 0x80, then a redirect combined with a stall.
    step(1, 1, 14'h80, 0, 0);
    step(1, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0);
    step(1, 1, 14'h90, 1, 0);
    step(1, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0);
    // Flush pulse, flush during a stall, stall over a bubble.
    step(1, 0, '0, 0, 1);
    step(1, 0, '0, 0, 0);
    step(1, 0, '0, 1, 0);
    step(1, 0, '0, 1, 1);
    step(1, 0, '0, 1, 0);
    step(1, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0);
    // Wrap at the top of the PC space.
    step(1, 1, 14'h3FFE, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, '0, 0, 0);
    // Reset while stalled and redirecting.
    step(1, 0, '0, 1, 0);
    step(0, 1, 14'h55, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 0, '0, 0, 0);

    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) >= 2,
           $urandom_range(0, 99) < 8,
           14'($urandom),
           $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 10);
    end

    @(posedge clock);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
